// File: rtl/systolic_skew_feeder.sv
// Edge operand injector for an N-lane systolic MAC array: skews each vector into a
// diagonal wavefront and sequences the clear / feed / flush / done pass.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start_i, no vectors accepted
// CLEAR | one-cycle synchronous clear of the array accumulators
// FEED  | accepting k vectors, bubbles inject zero slots
// FLUSH | 2N-1 cycles draining lane skew, array traversal and accumulate
// DONE  | one-cycle done pulse, array results are final
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4,
  parameter int K_W        = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [K_W-1:0]          k_len_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [N*DATA_WIDTH-1:0] in_data_i,
  output logic [N*DATA_WIDTH-1:0] lane_o,
  output logic [N-1:0]            lane_valid_o,
  output logic                    pe_rst_no,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam int FL_W = $clog2(2 * N);
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(2 * N - 2);

  state_t          state_q;
  logic [K_W-1:0]  k_q;
  logic [K_W-1:0]  acc_cnt_q;
  logic [K_W-1:0]  acc_cnt_nxt;
  logic [FL_W-1:0] flush_cnt_q;
  logic            hs;

  assign hs          = in_valid_i & in_ready_o;
  assign acc_cnt_nxt = acc_cnt_q + K_W'(1);

  // Lane i is i+1 registers deep; it shifts every cycle so stalls become zero slots.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] dat_q [i+1];
    logic [i:0]            vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int s = 0; s <= i; s++) dat_q[s] <= '0;
        vld_q <= '0;
      end else begin
        dat_q[0] <= hs ? in_data_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        vld_q[0] <= hs;
        for (int s = 1; s <= i; s++) begin
          dat_q[s] <= dat_q[s-1];
          vld_q[s] <= vld_q[s-1];
        end
      end
    end

    assign lane_o[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[i];
    assign lane_valid_o[i]                    = vld_q[i];
  end

  // Outputs are registered alongside the state so they change only with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      acc_cnt_q   <= '0;
      flush_cnt_q <= '0;
      in_ready_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pe_rst_no   <= 1'b1;
    end else begin
      done_o    <= 1'b0;
      pe_rst_no <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            k_q       <= k_len_i;
            acc_cnt_q <= '0;
            state_q   <= S_CLEAR;
            pe_rst_no <= 1'b0;
            busy_o    <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (k_q != '0) begin
            state_q    <= S_FEED;
            in_ready_o <= 1'b1;
          end else begin
            state_q <= S_DONE;
            done_o  <= 1'b1;
          end
        end
        S_FEED: begin
          if (hs) begin
            acc_cnt_q <= acc_cnt_nxt;
            if (acc_cnt_nxt == k_q) begin
              state_q     <= S_FLUSH;
              in_ready_o  <= 1'b0;
              flush_cnt_q <= FLUSH_LAST;
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_q <= S_DONE;
            done_o  <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q - FL_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: two feeders (A rows, B columns) drive a 4x4 MAC
// array model; lane slots are checked against a history scoreboard of accepted vectors.
module tb_systolic_skew_feeder;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int KW = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [KW-1:0] k_len_i;
  logic          in_valid_i;
  logic [N*DW-1:0] in_data_a, in_data_b;
  logic [N*DW-1:0] lane_a, lane_b;
  logic [N-1:0]  lane_valid_a, lane_valid_b;
  logic          ready_a, ready_b, pe_rst_na, pe_rst_nb, busy_a, busy_b, done_a, done_b;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N), .K_W(KW)) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .k_len_i(k_len_i),
    .in_valid_i(in_valid_i), .in_ready_o(ready_a), .in_data_i(in_data_a),
    .lane_o(lane_a), .lane_valid_o(lane_valid_a), .pe_rst_no(pe_rst_na),
    .busy_o(busy_a), .done_o(done_a));

  systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N), .K_W(KW)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .k_len_i(k_len_i),
    .in_valid_i(in_valid_i), .in_ready_o(ready_b), .in_data_i(in_data_b),
    .lane_o(lane_b), .lane_valid_o(lane_valid_b), .pe_rst_no(pe_rst_nb),
    .busy_o(busy_b), .done_o(done_b));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input bit rdy, input bit bsy, input bit dn, input bit pr);
    chk({tag, "_a"}, {ready_a, busy_a, done_a, pe_rst_na}, {rdy, bsy, dn, pr});
    chk({tag, "_b"}, {ready_b, busy_b, done_b, pe_rst_nb}, {rdy, bsy, dn, pr});
  endtask

  // Scoreboard: one entry per edge describing what entered the lane heads.
  typedef struct packed {
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
    logic            v;
  } vec_t;
  vec_t hist[$];
  vec_t push_e;
  vec_t pop_e;
  logic exp_hs = 1'b0;

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      hist.delete();
      repeat (N) hist.push_back('0);
    end else begin
      push_e.v = exp_hs;
      push_e.a = exp_hs ? in_data_a : '0;
      push_e.b = exp_hs ? in_data_b : '0;
      hist.push_back(push_e);
    end
  end

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      chk("rst_lanes", {lane_a, lane_b, lane_valid_a, lane_valid_b}, '0);
    end else if (hist.size() != N + 1) begin
      chk("sb_depth", hist.size(), N + 1);
    end else begin
      for (int i = 0; i < N; i++) begin
        pop_e = hist[N-i];
        chk("lane_a", lane_a[i*DW +: DW], pop_e.a[i*DW +: DW]);
        chk("lane_b", lane_b[i*DW +: DW], pop_e.b[i*DW +: DW]);
        chk("lane_v", {lane_valid_a[i], lane_valid_b[i]}, {pop_e.v, pop_e.v});
      end
      void'(hist.pop_front());
    end
  end

  // 4x4 output-stationary MAC array: A enters from the left, B from the top.
  logic [DW-1:0] pa [N][N];
  logic [DW-1:0] pb [N][N];
  logic [DW-1:0] acc [N][N];

  always @(posedge clk_i) begin
    logic [DW-1:0] ain, bin;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (c == 0) ain = lane_a[r*DW +: DW];
        else        ain = pa[r][c-1];
        if (r == 0) bin = lane_b[c*DW +: DW];
        else        bin = pb[r-1][c];
        pa[r][c] <= ain;
        pb[r][c] <= bin;
        if (!pe_rst_na) acc[r][c] <= '0;
        else            acc[r][c] <= acc[r][c] + ain * bin;
      end
    end
  end

  logic [N*DW-1:0] vec_a [256];
  logic [N*DW-1:0] vec_b [256];

  task automatic fill_vecs(input int k, input int maxv);
    for (int j = 0; j < k; j++)
      for (int l = 0; l < N; l++) begin
        vec_a[j][l*DW +: DW] = $urandom_range(0, maxv);
        vec_b[j][l*DW +: DW] = $urandom_range(0, maxv);
      end
  endtask

  task automatic check_matrix(input int k);
    logic [DW-1:0] ref_v;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ref_v = '0;
        for (int j = 0; j < k; j++)
          ref_v = ref_v + vec_a[j][r*DW +: DW] * vec_b[j][c*DW +: DW];
        chk($sformatf("acc_%0d_%0d", r, c), acc[r][c], ref_v);
      end
  endtask

  // One full pass; every control output is checked on every cycle.
  task automatic run_pass(input int k, input int gap, input bit start_in_flush, input bit chk_mat);
    int acc_n;
    int bub;
    @(negedge clk_i);
    start_i = 1'b1; k_len_i = KW'(k); in_valid_i = 1'b0; exp_hs = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    check_ctrl("clear", 0, 1, 0, 0);
    if (k == 0) begin
      in_valid_i = 1'b1;
      @(negedge clk_i);
      check_ctrl("k0_done", 0, 1, 1, 1);
      in_valid_i = 1'b0;
      @(negedge clk_i);
      check_ctrl("k0_idle", 0, 0, 0, 1);
      return;
    end
    acc_n = 0;
    bub   = 0;
    @(negedge clk_i);
    while (acc_n < k) begin
      check_ctrl("feed", 1, 1, 0, 1);
      if (bub > 0) begin
        in_valid_i = 1'b0; exp_hs = 1'b0; bub--;
      end else begin
        in_valid_i = 1'b1; in_data_a = vec_a[acc_n]; in_data_b = vec_b[acc_n];
        exp_hs = 1'b1; acc_n++; bub = gap;
      end
      @(negedge clk_i);
    end
    // A vector offered once FEED has ended must not be taken.
    in_valid_i = 1'b1; in_data_a = {N{32'hdead_beef}}; in_data_b = {N{32'hfeed_f00d}};
    exp_hs = 1'b0;
    start_i = start_in_flush;
    for (int f = 0; f < 2 * N - 1; f++) begin
      check_ctrl("flush", 0, 1, 0, 1);
      @(negedge clk_i);
    end
    in_valid_i = 1'b0; start_i = 1'b0;
    check_ctrl("done", 0, 1, 1, 1);
    if (chk_mat) check_matrix(k);
    @(negedge clk_i);
    check_ctrl("idle", 0, 0, 0, 1);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; k_len_i = '0; in_valid_i = 1'b0;
    in_data_a = '0; in_data_b = '0;
    repeat (2) @(negedge clk_i);
    check_ctrl("reset", 0, 0, 0, 1);
    #2 rst_ni = 1'b1;

    // Skew: lane0=1 .. lane3=4, each valid for one slot.
    vec_a[0] = {32'd4, 32'd3, 32'd2, 32'd1};
    vec_b[0] = {32'd8, 32'd7, 32'd6, 32'd5};
    run_pass(1, 0, 0, 1);

    fill_vecs(3, 32'hffff_ffff);
    run_pass(3, 0, 0, 0);

    fill_vecs(2, 255);
    run_pass(2, 2, 0, 1);

    fill_vecs(4, 255);
    run_pass(4, 1, 0, 1);

    run_pass(0, 0, 0, 0);

    fill_vecs(2, 255);
    run_pass(2, 0, 1, 1);

    // Asynchronous reset in the middle of FEED.
    fill_vecs(5, 255);
    @(negedge clk_i);
    start_i = 1'b1; k_len_i = KW'(5);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_i);
      in_valid_i = 1'b1; in_data_a = vec_a[j]; in_data_b = vec_b[j]; exp_hs = 1'b1;
    end
    @(negedge clk_i);
    in_valid_i = 1'b0; exp_hs = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check_ctrl("async_rst", 0, 0, 0, 1);
    chk("async_lanes", {lane_a, lane_valid_a}, '0);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;

    fill_vecs(1, 255);
    run_pass(1, 0, 0, 1);

    fill_vecs(255, 32'hffff_ffff);
    run_pass(255, 0, 0, 0);

    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Operand injector on one edge (left or top) of the N-lane systolic multiply-accumulate array.
- Accepts one K-step operand vector per handshake, one element per lane.
- Drives the array edge with lane i delayed i cycles, giving the diagonal wavefront the PEs require. Zeros are injected whenever no real data is present.
- Sequences a full matrix-product pass: clear, feed, flush, done. Array accumulators are guaranteed final when done_o pulses.

Parameters:
- DATA_WIDTH, 32, width of one operand element (matches PE operand width).
- N, 4, number of lanes (array rows/columns driven); N >= 2.
- K_W, 8, width of the k_len_i count; max pass length 2^K_W - 1.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  begin a pass; sampled only in IDLE.
- k_len_i  in  K_W  number of vectors in the pass; sampled with start_i.
- in_valid_i  in  1  in_data_i holds a valid vector.
- in_ready_o  out  1  feeder accepts a vector this cycle.
- in_data_i  in  N*DATA_WIDTH  vector; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- lane_o  out  N*DATA_WIDTH  skewed operands to the array edge (left_i/up_i of the edge PEs).
- lane_valid_o  out  N  per-lane marker: lane_o slot carries a real element.
- pe_rst_no  out  1  synchronous active-low clear to the array; low for exactly 1 cycle per pass.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse; array results final.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; all lane registers and lane_valid_o = 0.
  - in_ready_o=0, busy_o=0, done_o=0, pe_rst_no=1.
  - Counters = 0; the latched k is cleared.
  - Reset mid-pass aborts the pass with no done_o.
- Lane pipeline:
  - Lane i is a chain of i+1 registers and shifts every cycle in every state, including when stalled.
  - The head of each chain loads the accepted element when a handshake occurs. Otherwise it loads 0 with valid=0.
  - A vector accepted at edge t appears on lane i after edge t+1+i.
- FSM:
  - IDLE: in_ready_o=0. start_i=1 latches k_len_i and moves to CLEAR. in_valid_i is ignored.
  - CLEAR (1 cycle): pe_rst_no=0. Next state is FEED if latched k>0, else DONE.
  - FEED: in_ready_o=1. A handshake (in_valid_i & in_ready_o) increments the accept count.
    - The accept that brings the count to k moves to FLUSH on the same edge. in_ready_o is 0 from the next cycle.
    - in_valid_i low in FEED injects a zero bubble; the bubble contributes a zero product to the accumulators.
  - FLUSH: in_ready_o=0. Lasts exactly 2N-1 cycles, counted by the flush counter, then moves to DONE. This covers lane skew (N-1), array traversal (N-1) and PE accumulation (1).
  - DONE (1 cycle): done_o=1, then IDLE.
- start_i outside IDLE is ignored; a new pass needs a fresh start_i in IDLE.
- Because in_ready_o depends only on state, a vector offered exactly as FEED ends is not accepted.
- busy_o = (state != IDLE). done_o and pe_rst_no are registered, glitch-free outputs.
- Data is passed through unmodified, with no arithmetic and no width change. lane_valid_o follows its data through the same chain.

Test Plan:
- Reset values: assert rst_ni=0 mid-FEED (N=4) -> lane_o=0, lane_valid_o=0, in_ready_o=0, busy_o=0, done_o=0, pe_rst_no=1 immediately (asynchronously). After release, state is IDLE and a subsequent start_i is honoured.
- Skew check: N=4, k_len=1, vector {4,3,2,1} (lane0=1) accepted at edge t.
  - lane0=1 after t+1, lane1=2 after t+2, lane2=3 after t+3, lane3=4 after t+4.
  - Each lane_valid_o bit is high for exactly one cycle.
  - done_o pulses 2N-1=7 flush cycles after the accept cycle.
- Sequencing: start_i with k_len=3 -> pe_rst_no low for exactly 1 cycle, then in_ready_o high. Three back-to-back accepts -> in_ready_o drops after the 3rd, exactly one done_o pulse, busy_o low the next cycle.
- Stall/bubbles: k_len=2 with in_valid_i low for 2 cycles between vectors -> 2 zero slots (valid=0) appear on every lane between the two elements, and the flush still starts only after the 2nd accept. End-to-end, with a 4x4 array model, the result equals the A*B reference product.
- Boundaries:
  - k_len=0 -> CLEAR then DONE: done_o 2 cycles after start_i, no accept.
  - start_i asserted during FLUSH -> ignored, no second pe_rst_no pulse.
  - k_len=255 (K_W=8) completes with exactly 255 accepts.
